// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the iterative RV32M multiply/divide unit.
// The core drives the request side (master); the unit drives status and result (slave).
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
) ();

   logic            start;
   logic            kill;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, kill, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, op, a, b,
      output busy, done, result
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring divider sharing one
// accumulator pair; operands are converted to magnitudes on accept and sign-fixed at the end.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);

   localparam int unsigned CntW = $clog2(XLEN);

   localparam logic [2:0] OpMul    = 3'd0;
   localparam logic [2:0] OpMulh   = 3'd1;
   localparam logic [2:0] OpMulhsu = 3'd2;
   localparam logic [2:0] OpMulhu  = 3'd3;
   localparam logic [2:0] OpDiv    = 3'd4;
   localparam logic [2:0] OpDivu   = 3'd5;
   localparam logic [2:0] OpRem    = 3'd6;
   localparam logic [2:0] OpRemu   = 3'd7;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
   logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Accept-time operand decode
   logic              sgn_a, sgn_b, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;

   assign sgn_a = (bus.op == OpMulh) || (bus.op == OpMulhsu) ||
                  (bus.op == OpDiv)  || (bus.op == OpRem);
   assign sgn_b = (bus.op == OpMulh) || (bus.op == OpDiv) || (bus.op == OpRem);
   assign neg_a = sgn_a & bus.a[XLEN-1];
   assign neg_b = sgn_b & bus.b[XLEN-1];
   assign mag_a = neg_a ? -bus.a : bus.a;
   assign mag_b = neg_b ? -bus.b : bus.b;

   assign div_zero = bus.op[2] && (bus.b == '0);
   assign div_ovf  = ((bus.op == OpDiv) || (bus.op == OpRem)) &&
                     (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == {XLEN{1'b1}});
   assign special  = div_zero || div_ovf;

   // op[1] separates REM/REMU from DIV/DIVU
   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = bus.op[1] ? bus.a : {XLEN{1'b1}};
      end else if (div_ovf) begin
         special_res = bus.op[1] ? '0 : bus.a;
      end
   end

   // Multiply step: conditionally add multiplicand to the upper half, then shift right
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN:0]   mul_shift;

   assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mcand_q : {XLEN{1'b0}})};
   assign mul_shift = {mul_sum, acc_lo_q};

   // Divide step: shift next dividend bit into the remainder and trial-subtract
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     rem_diff;

   assign rem_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
   assign rem_diff  = rem_shift - {1'b0, mcand_q};

   // Final sign fix-up
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;
   logic [XLEN-1:0]   fix_res;

   assign prod_fix = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
   assign rem_fix  = neg_a_q ? -acc_hi_q : acc_hi_q;

   always_comb begin
      fix_res = '0;
      unique case (op_q)
         OpMul:                     fix_res = prod_fix[XLEN-1:0];
         OpMulh, OpMulhsu, OpMulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
         OpDiv, OpDivu:             fix_res = quo_fix;
         OpRem, OpRemu:             fix_res = rem_fix;
         default:                   fix_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      mcand_d  = mcand_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      result_d = result_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               op_d     = bus.op;
               neg_a_d  = neg_a;
               neg_b_d  = neg_b;
               acc_hi_d = '0;
               // Multiplier/dividend goes in the low half, the other operand stays fixed
               acc_lo_d = bus.op[2] ? mag_a : mag_b;
               mcand_d  = bus.op[2] ? mag_b : mag_a;
               if (special) begin
                  result_d = special_res;
                  state_d  = StDone;
               end else begin
                  cnt_d   = CntW'(XLEN - 1);
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (op_q[2]) begin
               if (!rem_diff[XLEN]) begin
                  acc_hi_d = rem_diff[XLEN-1:0];
                  acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_hi_d = rem_shift[XLEN-1:0];
                  acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_shift[2*XLEN:XLEN+1];
               acc_lo_d = mul_shift[XLEN:1];
            end
            if (cnt_q == '0) begin
               state_d = StFix;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StFix: begin
            result_d = fix_res;
            state_d  = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (bus.kill) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_q     <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         mcand_q  <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         mcand_q  <= mcand_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors with literal expectations, plus an arithmetic
// reference model compared against busy/done/result on every cycle.
module tb_muldiv_unit;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   muldiv_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the RV32M definitions
   function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic logic model_special(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      return op[2] && ((b == 0) ||
             (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   // Model: m_left counts edges until the unit is idle again; done is its last cycle
   int          m_left;
   logic [31:0] m_res, m_pend;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_res  <= '0;
         m_pend <= '0;
      end else if (bus.kill) begin
         m_left <= 0;
      end else if (m_left == 0) begin
         if (bus.start) begin
            m_pend <= model_res(bus.op, bus.a, bus.b);
            if (model_special(bus.op, bus.a, bus.b)) begin
               m_left <= 1;
               m_res  <= model_res(bus.op, bus.a, bus.b);
            end else begin
               m_left <= XLEN + 2;
            end
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 2) m_res <= m_pend;
      end
   end

   always @(negedge clk) begin
      check("busy vs model", {31'd0, bus.busy}, {31'd0, (m_left != 0)});
      check("done vs model", {31'd0, bus.done}, {31'd0, (m_left == 1)});
      check("result vs model", bus.result, m_res);
   end

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      @(negedge clk);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, " result"}, bus.result, exp_res);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          n_done;
      int          cyc;
      int          t_done[2];
      logic [31:0] seen;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Multiply
      run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      // Divide
      run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("REM -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
      run_op("REMU 100%7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
      run_op("DIV 7/-2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      run_op("REM 7%-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
      // Special cases
      run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("REM 5%0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
      run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

      // Start pulse during CALC is ignored
      @(negedge clk);
      bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_done = 0;
      seen   = '0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            n_done++;
            seen = bus.result;
         end
      end
      check("ignored start done count", 32'(n_done), 32'd1);
      check("ignored start result", seen, 32'd15);

      // Continuous start: one accept per 35 cycles
      @(negedge clk);
      bus.op = 3'd3; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
      n_done = 0;
      cyc    = 0;
      t_done = '{0, 0};
      while (n_done < 2 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.done) begin
            t_done[n_done] = cyc;
            n_done++;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
      check("held start done pulses", 32'(n_done), 32'd2);
      check("held start spacing", 32'(t_done[1] - t_done[0]), 32'd35);
      check("held start result", bus.result, 32'hFFFF_FFFE);
      repeat (2) @(posedge clk);

      // Kill mid-multiply
      @(negedge clk);
      bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.kill = 1'b1;
      @(posedge clk);
      #1;
      bus.kill = 1'b0;
      check("kill busy", {31'd0, bus.busy}, 32'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) n_done++;
      end
      check("kill done count", 32'(n_done), 32'd0);
      check("kill result held", bus.result, 32'hFFFF_FFFE);

      // Asynchronous reset mid-divide
      @(negedge clk);
      bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async rst busy", {31'd0, bus.busy}, 32'd0);
      check("async rst done", {31'd0, bus.done}, 32'd0);
      check("async rst result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12, 34);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit. Operands come from the ALU operand-select multiplexers; the result feeds the writeback-select multiplexer.
- Start/busy/done handshake; the core's control logic freezes the PC while `busy` is high.
- One multicycle datapath is shared by all eight M-extension operations: a radix-2 shift-add multiplier and a restoring divider.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- kill  in  1  synchronous abort (pipeline flush)
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  in  XLEN  rs1 operand; sampled only on accept
- b  in  XLEN  rs2 operand; sampled only on accept
- busy  out  1  high whenever state is not IDLE
- done  out  1  single-cycle pulse; result valid
- result  out  XLEN  registered result; held until the next accept

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. A reset during any operation aborts it; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1 in IDLE at edge k. The unit latches op, a, b and the operand signs. The signed operands are converted to magnitudes:
  - MULH: both operands.
  - MULHSU: a only.
  - DIV/REM: both operands.
- Accept transitions:
  - Special division case: go to DONE.
  - Otherwise: go to CALC with the iteration counter set to XLEN-1.
- CALC: one iteration per cycle.
  - Multiply: 2*XLEN-bit accumulator.
  - Divide: restoring step, shifting the quotient and remainder left by one.
  - When the counter reaches 0, go to FIX; otherwise decrement the counter.
- FIX:
  - Apply two's-complement negation when required:
    - Product sign = sign(a) XOR sign(b) for the signed operand kinds.
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign(a).
  - Select the result:
    - MUL: low XLEN bits of the product.
    - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - Register the selected result, then go to DONE.
- DONE: done=1 for exactly this cycle; next state is IDLE.
- Latency:
  - Normal operations: done is high in the cycle after edge k+XLEN+1, i.e. XLEN+2 cycles after the accept edge (34 for XLEN=32).
  - Special cases: done is high in the cycle after edge k (1 cycle).
- Special cases, decided at accept, with no iteration:
  - Divide by zero (b=0):
    - DIV, DIVU: result = all-ones.
    - REM, REMU: result = a.
  - Signed overflow (a=100…0, b=all-ones):
    - DIV: result = a.
    - REM: result = 0.
- Division results truncate toward zero. The remainder takes the sign of the dividend.
- start while busy=1 is ignored: no re-latch, current operation unaffected.
- start in the DONE cycle is ignored. A new request is accepted in IDLE only, so the earliest back-to-back accept is the edge after done.
- kill=1 at any edge:
  - Next state is IDLE and done=0.
  - result keeps its previous value.
  - kill has priority over start in the same cycle.
- result changes only on the FIX→DONE edge (normal operations) or the IDLE→DONE edge (special cases). It is stable at all other times, including while busy.
- busy covers CALC, FIX and DONE. It is low in IDLE, including on the accept cycle before the first edge.

Test Plan:
- Multiply:
  - MUL a=7, b=0xFFFFFFFD (−3): done exactly 34 cycles after the accept edge, result=0xFFFFFFEB.
  - MULH a=b=0x80000000: result=0x40000000.
  - MULHU a=b=0xFFFFFFFF: result=0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF: result=0xFFFFFFFF.
- Signed/unsigned divide:
  - DIV a=0xFFFFFFF9 (−7), b=2: result=0xFFFFFFFD.
  - REM, same operands: result=0xFFFFFFFF.
  - DIVU a=100, b=7: result=14.
  - REMU, same operands: result=2.
- Special cases (done 1 cycle after the accept edge):
  - DIVU a=5, b=0: result=0xFFFFFFFF.
  - REM a=5, b=0: result=5.
  - DIV a=0x80000000, b=0xFFFFFFFF: result=0x80000000.
  - REM, same operands: result=0.
- Handshake:
  - Pulse start during CALC with different operands: ignored, first result unchanged, exactly one done pulse.
  - Hold start high continuously: a new accept every 35 cycles (34 to done plus the IDLE cycle).
  - result stays stable between done pulses.
- Abort/reset:
  - kill at cycle 10 of a MUL: busy drops after the next edge, no done, result retains its prior value.
  - Assert rst asynchronously mid-DIV: busy, done and result go to 0 immediately without waiting for a clock edge.
  - After reset releases, a fresh MUL 3×4 returns result=12.
